// File: rtl/bcd_ex3_seq_ctrl.sv
// BCD sequence generator with excess-3 output: steps bcd from lo to hi, one digit per DIV
// clocks, and holds each code under a valid/ready handshake (run-once or continuous).
module bcd_ex3_seq_ctrl #(
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       cont,
  input  logic [3:0] lo,
  input  logic [3:0] hi,
  input  logic       out_ready,
  output logic [3:0] bcd,
  output logic [3:0] ex3,
  output logic       out_valid,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    WAIT,
    DONE,
    ERR
  } state_t;

  localparam logic [3:0] PRESC_LAST = 4'(DIV - 1);

  state_t     state_q, state_d;
  logic [3:0] bcd_q, bcd_d;
  logic [3:0] ex3_q, ex3_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [3:0] presc_q, presc_d;
  logic [3:0] lo_q, lo_d;
  logic [3:0] hi_q, hi_d;
  logic       cont_q, cont_d;

  // Next-state logic; abort overrides everything so no capture can happen in the same cycle.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    done_d  = done_q;
    err_d   = err_q;
    presc_d = presc_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    cont_d  = cont_q;

    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      presc_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if ((lo <= 4'd9) && (hi <= 4'd9) && (lo <= hi)) begin
              lo_d    = lo;
              hi_d    = hi;
              cont_d  = cont;
              bcd_d   = lo;
              presc_d = 4'd0;
              state_d = RUN;
            end else begin
              err_d   = 1'b1;
              state_d = ERR;
            end
          end
        end
        RUN: begin
          if (presc_q == PRESC_LAST) begin
            valid_d = 1'b1;
            presc_d = 4'd0;
            state_d = WAIT;
          end else begin
            presc_d = presc_q + 4'd1;
          end
        end
        WAIT: begin
          if (out_ready) begin
            valid_d = 1'b0;
            if (bcd_q != hi_q) begin
              bcd_d   = bcd_q + 4'd1;
              state_d = RUN;
            end else if (cont_q) begin
              bcd_d   = lo_q;
              state_d = RUN;
            end else begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          done_d  = 1'b0;
          presc_d = 4'd0;
        end
      endcase
    end
  end

  // Derived outputs are computed from next-state values so they stay registered yet coherent.
  always_comb begin
    ex3_d  = bcd_d + 4'd3;
    busy_d = (state_d == RUN) || (state_d == WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_q   <= 4'd0;
      ex3_q   <= 4'd3;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      presc_q <= 4'd0;
      lo_q    <= 4'd0;
      hi_q    <= 4'd0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      ex3_q   <= ex3_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      presc_q <= presc_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      cont_q  <= cont_d;
    end
  end

  assign bcd       = bcd_q;
  assign ex3       = ex3_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_ex3_seq_ctrl.sv
// Directed bench for bcd_ex3_seq_ctrl: a DIV=1 instance driven from a vector table plus
// hand-written sequences, and a DIV=4 instance for step timing in continuous mode.
module tb_bcd_ex3_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start4, abort, cont, outReady;
  logic [3:0] lo, hi;

  logic [3:0] bcd1, ex31, bcd4, ex34;
  logic       vld1, busy1, done1, err1;
  logic       vld4, busy4, done4, err4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_ex3_seq_ctrl #(.DIV(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .cont(cont),
    .lo(lo), .hi(hi), .out_ready(outReady),
    .bcd(bcd1), .ex3(ex31), .out_valid(vld1), .busy(busy1), .done(done1), .err(err1)
  );

  bcd_ex3_seq_ctrl #(.DIV(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort), .cont(cont),
    .lo(lo), .hi(hi), .out_ready(outReady),
    .bcd(bcd4), .ex3(ex34), .out_valid(vld4), .busy(busy4), .done(done4), .err(err4)
  );

  typedef struct {
    string      name;
    logic       start, abort, cont;
    logic [3:0] lo, hi;
    logic       rdy;
    logic [3:0] eBcd, eEx3;
    logic       eVld, eBusy, eDone, eErr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic s, a, c, input logic [3:0] l, h,
                              input logic r, input logic [3:0] b, e,
                              input logic v, bu, d, er);
    vec_t t;
    t.name = n; t.start = s; t.abort = a; t.cont = c; t.lo = l; t.hi = h; t.rdy = r;
    t.eBcd = b; t.eEx3 = e; t.eVld = v; t.eBusy = bu; t.eDone = d; t.eErr = er;
    return t;
  endfunction

  function automatic logic [13:0] obs1();
    return {bcd1, ex31, vld1, busy1, done1, err1};
  endfunction

  function automatic logic [13:0] expv(input logic [3:0] b, e, input logic v, bu, d, er);
    return {b, e, v, bu, d, er};
  endfunction

  // Drives the DIV=1 instance for one clock, leaving time just after the edge for sampling.
  task automatic applyStimulus(input logic s, a, c, input logic [3:0] l, h, input logic r);
    start1 = s; abort = a; cont = c; lo = l; hi = h; outReady = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [13:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got {bcd,ex3,vld,busy,done,err}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic checkVal(input string name, input int act, exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int cnt;
    int doneSeen;
    logic [3:0] expSeq [3];

    rst = 1'b1; start1 = 0; start4 = 0; abort = 0; cont = 0; lo = 0; hi = 0; outReady = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_u1", obs1(), expv(4'd0, 4'd3, 0, 0, 0, 0));
    checkOutput("reset_u4", {bcd4, ex34, vld4, busy4, done4, err4}, expv(4'd0, 4'd3, 0, 0, 0, 0));
    rst = 1'b0;

    vecs.push_back(mk("err_lo_gt_hi",    1,0,0, 4'd7,4'd3,0, 4'd0,4'd3, 0,0,0,1));
    vecs.push_back(mk("err_sticky",      0,0,0, 4'd7,4'd3,0, 4'd0,4'd3, 0,0,0,1));
    vecs.push_back(mk("err_start_ign",   1,0,0, 4'd2,4'd4,0, 4'd0,4'd3, 0,0,0,1));
    vecs.push_back(mk("err_abort",       0,1,0, 4'd2,4'd4,0, 4'd0,4'd3, 0,0,0,0));
    vecs.push_back(mk("err_hi_10",       1,0,0, 4'd0,4'd10,0,4'd0,4'd3, 0,0,0,1));
    vecs.push_back(mk("err_abort2",      0,1,0, 4'd0,4'd10,0,4'd0,4'd3, 0,0,0,0));
    vecs.push_back(mk("start_abort_idle",1,1,0, 4'd2,4'd4,0, 4'd0,4'd3, 0,0,0,0));
    vecs.push_back(mk("idle_after_both", 0,0,0, 4'd2,4'd4,0, 4'd0,4'd3, 0,0,0,0));
    vecs.push_back(mk("eq_start",        1,0,0, 4'd5,4'd5,0, 4'd5,4'd8, 0,1,0,0));
    vecs.push_back(mk("eq_wait0",        0,0,0, 4'd5,4'd5,0, 4'd5,4'd8, 1,1,0,0));
    vecs.push_back(mk("eq_wait1_newcfg", 0,0,1, 4'd1,4'd9,0, 4'd5,4'd8, 1,1,0,0));
    vecs.push_back(mk("eq_wait2_start",  1,0,1, 4'd1,4'd9,0, 4'd5,4'd8, 1,1,0,0));
    vecs.push_back(mk("eq_wait3",        0,0,1, 4'd1,4'd9,0, 4'd5,4'd8, 1,1,0,0));
    vecs.push_back(mk("eq_wait4",        0,0,0, 4'd1,4'd9,0, 4'd5,4'd8, 1,1,0,0));
    vecs.push_back(mk("eq_wait5",        0,0,0, 4'd1,4'd9,0, 4'd5,4'd8, 1,1,0,0));
    vecs.push_back(mk("eq_wait6",        0,0,0, 4'd1,4'd9,0, 4'd5,4'd8, 1,1,0,0));
    vecs.push_back(mk("eq_accept_done",  0,0,0, 4'd1,4'd9,1, 4'd5,4'd8, 0,0,1,0));
    vecs.push_back(mk("done_start_ign",  1,0,0, 4'd1,4'd9,1, 4'd5,4'd8, 0,0,0,0));
    vecs.push_back(mk("idle_after_done", 0,0,0, 4'd1,4'd9,1, 4'd5,4'd8, 0,0,0,0));
    vecs.push_back(mk("wrap_start",      1,0,1, 4'd3,4'd3,1, 4'd3,4'd6, 0,1,0,0));
    vecs.push_back(mk("wrap_wait",       0,0,0, 4'd3,4'd3,1, 4'd3,4'd6, 1,1,0,0));
    vecs.push_back(mk("wrap_run",        0,0,0, 4'd3,4'd3,1, 4'd3,4'd6, 0,1,0,0));
    vecs.push_back(mk("wrap_wait2",      0,0,0, 4'd3,4'd3,1, 4'd3,4'd6, 1,1,0,0));
    vecs.push_back(mk("wrap_abort",      0,1,0, 4'd3,4'd3,1, 4'd3,4'd6, 0,0,0,0));
    vecs.push_back(mk("idle_after_abort",0,0,0, 4'd3,4'd3,1, 4'd3,4'd6, 0,0,0,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].abort, vecs[i].cont, vecs[i].lo, vecs[i].hi, vecs[i].rdy);
      checkOutput(vecs[i].name, obs1(),
                  expv(vecs[i].eBcd, vecs[i].eEx3, vecs[i].eVld, vecs[i].eBusy,
                       vecs[i].eDone, vecs[i].eErr));
    end

    // Full 0..9 run-once sweep at DIV=1 with the consumer always ready.
    applyStimulus(1, 0, 0, 4'd0, 4'd9, 1);
    checkOutput("sweep_start", obs1(), expv(4'd0, 4'd3, 0, 1, 0, 0));
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, 0, 4'd0, 4'd9, 1);
      checkOutput($sformatf("sweep_valid_%0d", k), obs1(),
                  expv(4'(k), 4'(k + 3), 1, 1, 0, 0));
      applyStimulus(0, 0, 0, 4'd0, 4'd9, 1);
      if (k < 9)
        checkOutput($sformatf("sweep_step_%0d", k), obs1(),
                    expv(4'(k + 1), 4'(k + 4), 0, 1, 0, 0));
      else
        checkOutput("sweep_done", obs1(), expv(4'd9, 4'd12, 0, 0, 1, 0));
    end
    applyStimulus(0, 0, 0, 4'd0, 4'd9, 1);
    checkOutput("sweep_idle", obs1(), expv(4'd9, 4'd12, 0, 0, 0, 0));

    // DIV=4 continuous run: first code 4 edges after start, then one every 5 edges.
    expSeq[0] = 4'd2; expSeq[1] = 4'd3; expSeq[2] = 4'd4;
    lo = 4'd2; hi = 4'd4; cont = 1'b1; outReady = 1'b1; start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 6; i++) begin
      cnt = 0;
      do begin
        @(posedge clk);
        #1;
        cnt++;
        if (done4) doneSeen++;
      end while (!vld4 && cnt < 12);
      checkVal($sformatf("div4_gap_%0d", i), cnt, (i == 0) ? 4 : 5);
      checkVal($sformatf("div4_bcd_%0d", i), int'(bcd4), int'(expSeq[i % 3]));
      checkVal($sformatf("div4_ex3_%0d", i), int'(ex34), int'(expSeq[i % 3]) + 3);
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkVal("div4_abort_valid", int'(vld4), 0);
    checkVal("div4_abort_busy", int'(busy4), 0);
    checkVal("div4_abort_done", int'(done4), 0);
    checkVal("div4_no_done", doneSeen, 0);
    cont = 1'b0;

    // Asynchronous reset while waiting on bcd=6, then a clean restart.
    applyStimulus(1, 0, 0, 4'd6, 4'd8, 0);
    checkOutput("rst_seq_run", obs1(), expv(4'd6, 4'd9, 0, 1, 0, 0));
    applyStimulus(0, 0, 0, 4'd6, 4'd8, 0);
    checkOutput("rst_seq_wait", obs1(), expv(4'd6, 4'd9, 1, 1, 0, 0));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async", obs1(), expv(4'd0, 4'd3, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 4'd6, 4'd8, 1);
      checkOutput($sformatf("rst_after_%0d", i), obs1(), expv(4'd0, 4'd3, 0, 0, 0, 0));
    end
    applyStimulus(1, 0, 0, 4'd6, 4'd6, 1);
    checkOutput("restart_run", obs1(), expv(4'd6, 4'd9, 0, 1, 0, 0));
    applyStimulus(0, 0, 0, 4'd6, 4'd6, 1);
    checkOutput("restart_wait", obs1(), expv(4'd6, 4'd9, 1, 1, 0, 0));
    applyStimulus(0, 0, 0, 4'd6, 4'd6, 1);
    checkOutput("restart_done", obs1(), expv(4'd6, 4'd9, 0, 0, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_ex3_seq_ctrl.md
BCD_EX3_SEQ_CTRL -- requirements
Module: bcd_ex3_seq_ctrl

Interface
REQ-001 SHALL have parameter DIV, default 1, meaning clock cycles per sequence step (legal range 1..16).
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, level-sampled request to begin a sequence.
REQ-005 SHALL have port abort, input, 1, cancel the sequence and return to idle.
REQ-006 SHALL have port cont, input, 1, continuous mode: 1 = wrap hi->lo forever, 0 = run once.
REQ-007 SHALL have port lo, input, 4, first BCD digit of the sequence.
REQ-008 SHALL have port hi, input, 4, last BCD digit of the sequence.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the current code.
REQ-010 SHALL have port bcd, output, 4, current BCD digit.
REQ-011 SHALL have port ex3, output, 4, excess-3 code of bcd (bit3..0 = w,x,y,z).
REQ-012 SHALL have port out_valid, output, 1, bcd/ex3 valid for handshake.
REQ-013 SHALL have port busy, output, 1, high in RUN or WAIT.
REQ-014 SHALL have port done, output, 1, one-cycle pulse at end of a run-once sequence.
REQ-015 SHALL have port err, output, 1, sticky configuration error flag.

Function
REQ-016 SHALL implement states IDLE, RUN, WAIT, DONE, ERR; all outputs registered.
REQ-017 SHALL keep ex3 equal to bcd+3 (4-bit) in the same cycle as bcd at all times.
REQ-018 IDLE: on start=1 with lo<=9, hi<=9, lo<=hi: capture lo/hi/cont, bcd<=lo, clear prescaler, go RUN.
REQ-019 IDLE: on start=1 with lo>9, hi>9 or lo>hi: set err=1, go ERR; bcd unchanged.
REQ-020 RUN: prescaler increments each cycle; when it equals DIV-1, set out_valid=1, clear prescaler, go WAIT.
REQ-021 Latency: start sampled at edge N -> out_valid first high after edge N+DIV.
REQ-022 WAIT: bcd, ex3, out_valid SHALL hold stable while out_ready=0, for any number of cycles.
REQ-023 WAIT with out_ready=1 and bcd!=hi: out_valid<=0, bcd<=bcd+1, go RUN.
REQ-024 WAIT with out_ready=1, bcd==hi, captured cont=1: out_valid<=0, bcd<=lo, go RUN (wrap).
REQ-025 WAIT with out_ready=1, bcd==hi, captured cont=0: out_valid<=0, go DONE; bcd holds hi.
REQ-026 DONE: done=1 for exactly that cycle, then IDLE unconditionally; start in DONE ignored.
REQ-027 ERR: err stays 1 until abort=1 or rst; abort -> err<=0, IDLE.
REQ-028 start SHALL be ignored outside IDLE; lo/hi/cont changes after capture SHALL have no effect.
REQ-029 abort=1 in any state SHALL force IDLE next edge, out_valid<=0, done<=0, prescaler cleared; abort wins over start and out_ready in the same cycle.
REQ-030 lo==hi SHALL produce exactly one accepted code per run-once sequence (or the same code repeatedly when cont=1).
REQ-031 out_valid SHALL never be high outside WAIT; busy = (state==RUN or WAIT).

Reset
REQ-032 On rst=1, asynchronously: state IDLE, bcd=0, ex3=3, out_valid=0, busy=0, done=0, err=0, prescaler=0.
REQ-033 rst asserted mid-sequence (RUN or WAIT) SHALL discard the sequence; no done pulse after release.
REQ-034 First start after rst release SHALL behave per REQ-018/019 with no residual state.

Verification
REQ-035 DIV=1, lo=0, hi=9, cont=0, out_ready=1: accepted codes 3,4,...,12 in order, done pulses one cycle after ex3=12 accepted, then IDLE.
REQ-036 DIV=4, lo=2, hi=4, cont=1, out_ready=1: out_valid every 5 cycles, bcd 2,3,4,2,3..., no done; abort -> IDLE next edge, out_valid=0.
REQ-037 lo=5, hi=5, out_ready held 0 for 7 cycles: bcd=5, ex3=8, out_valid=1 stable all 7 cycles; then out_ready=1 -> done pulse.
REQ-038 start with lo=7, hi=3 (and separately hi=10): err=1, busy=0, stays until abort=1, then err=0, IDLE.
REQ-039 rst pulsed while in WAIT at bcd=6: immediately bcd=0, ex3=3, out_valid=0; no done pulse after release.
REQ-040 start and abort both high in IDLE: remains IDLE, busy=0; start in WAIT: ignored, sequence unaffected.
